// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and helpers for the serial magnitude comparator
package cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } cmp_state_t;

    localparam logic CMP_UNSIGNED = 1'b0;
    localparam logic CMP_SIGNED   = 1'b1;

    // Counter width able to hold the values 0..ndig
    function automatic int calc_cw(input int ndig);
        return $clog2(ndig + 1);
    endfunction

endpackage

// File: rtl/digit_compare.sv
// rtl/digit_compare.sv - combinational unsigned compare of one digit
module digit_compare #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] da,
    input  logic [DIGIT-1:0] db,
    output logic             gt,
    output logic             lt
);

    assign gt = (da > db);
    assign lt = (da < db);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - MSB-first digit-serial signed/unsigned comparator
module serial_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DIGIT = 4,
    localparam int NDIG  = WIDTH / DIGIT,
    localparam int CW    = calc_cw(NDIG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             greater,
    output logic             lower,
    output logic [CW-1:0]    digits_used
);

    localparam logic [CW-1:0] LAST_DIGIT = CW'(NDIG);

    cmp_state_t       state, state_d;
    logic [WIDTH-1:0] sa, sa_d;
    logic [WIDTH-1:0] sb, sb_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [CW-1:0]    digits_used_d;
    logic             equal_d, greater_d, lower_d, done_d;
    logic             dig_gt, dig_lt;

    digit_compare #(.DIGIT(DIGIT)) u_digit_compare (
        .da (sa[WIDTH-1 -: DIGIT]),
        .db (sb[WIDTH-1 -: DIGIT]),
        .gt (dig_gt),
        .lt (dig_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sa          <= '0;
            sb          <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            equal       <= 1'b0;
            greater     <= 1'b0;
            lower       <= 1'b0;
            digits_used <= '0;
        end else begin
            state       <= state_d;
            sa          <= sa_d;
            sb          <= sb_d;
            cnt         <= cnt_d;
            done        <= done_d;
            equal       <= equal_d;
            greater     <= greater_d;
            lower       <= lower_d;
            digits_used <= digits_used_d;
        end
    end

    always_comb begin
        state_d       = state;
        sa_d          = sa;
        sb_d          = sb;
        cnt_d         = cnt;
        done_d        = 1'b0;
        equal_d       = equal;
        greater_d     = greater;
        lower_d       = lower;
        digits_used_d = digits_used;
        case (state)
            IDLE: begin
                if (start) begin
                    // Flipping the sign bit maps two's complement onto unsigned order
                    sa_d            = a;
                    sb_d            = b;
                    sa_d[WIDTH-1]   = a[WIDTH-1] ^ (signed_mode == CMP_SIGNED);
                    sb_d[WIDTH-1]   = b[WIDTH-1] ^ (signed_mode == CMP_SIGNED);
                    cnt_d           = CW'(1);
                    equal_d         = 1'b0;
                    greater_d       = 1'b0;
                    lower_d         = 1'b0;
                    state_d         = CMP;
                end
            end
            CMP: begin
                if (dig_gt || dig_lt) begin
                    greater_d     = dig_gt;
                    lower_d       = dig_lt;
                    digits_used_d = cnt;
                    done_d        = 1'b1;
                    state_d       = IDLE;
                end else if (cnt == LAST_DIGIT) begin
                    equal_d       = 1'b1;
                    digits_used_d = LAST_DIGIT;
                    done_d        = 1'b1;
                    state_d       = IDLE;
                end else begin
                    sa_d  = sa << DIGIT;
                    sb_d  = sb << DIGIT;
                    cnt_d = cnt + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state == CMP);

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - directed self-checking bench for the serial comparator
module tb_serial_magnitude_comparator;

    localparam logic [2:0] R_NONE = 3'b000;
    localparam logic [2:0] R_EQ   = 3'b100;
    localparam logic [2:0] R_GT   = 3'b010;
    localparam logic [2:0] R_LT   = 3'b001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start = 1'b0, smode = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, equal, greater, lower;
    logic [2:0]  digits_used;

    logic        s_start = 1'b0, s_smode = 1'b0;
    logic [3:0]  s_a = '0, s_b = '0;
    logic        s_busy, s_done, s_equal, s_greater, s_lower;
    logic [2:0]  s_digits_used;

    int checks = 0;
    int errors = 0;
    int lat;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(smode),
        .a(a), .b(b), .busy(busy), .done(done), .equal(equal),
        .greater(greater), .lower(lower), .digits_used(digits_used)
    );

    serial_magnitude_comparator #(.WIDTH(4), .DIGIT(1)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .signed_mode(s_smode),
        .a(s_a), .b(s_b), .busy(s_busy), .done(s_done), .equal(s_equal),
        .greater(s_greater), .lower(s_lower), .digits_used(s_digits_used)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at the negedge just after the accepting edge
    task automatic launch(input logic m, input logic [15:0] va, input logic [15:0] vb);
        @(negedge clk);
        start = 1'b1; smode = m; a = va; b = vb;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
    endtask

    task automatic run(input string tag, input logic m, input logic [15:0] va,
                       input logic [15:0] vb, input logic [2:0] res, input int k);
        int n;
        launch(m, va, vb);
        check({tag, " busy"}, {31'd0, busy}, 32'd1);
        wait_done(n);
        check({tag, " result"}, {29'd0, equal, greater, lower}, {29'd0, res});
        check({tag, " latency"}, n, k);
        check({tag, " digits_used"}, {29'd0, digits_used}, k);
        check({tag, " busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic signed [3:0] sxa, sxb;
        logic [2:0]        exp_s;
        int                n;
        int                stray_done;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst outputs", {26'd0, busy, done, equal, greater, lower, 1'b0}, 32'd0);
        check("rst digits_used", {29'd0, digits_used}, 32'd0);
        rst_n = 1'b1;

        run("s1 eq",        1'b0, 16'h1234, 16'h1234, R_EQ, 4);
        @(negedge clk);
        check("s1 hold", {28'd0, done, equal, greater, lower}, 32'b0100);
        run("s2 u msb",     1'b0, 16'h8000, 16'h7FFF, R_GT, 1);
        run("s2 s msb",     1'b1, 16'h8000, 16'h7FFF, R_LT, 1);
        run("s3 s neg",     1'b1, 16'hFFFE, 16'hFFFF, R_LT, 4);
        run("s3 u lsb",     1'b0, 16'h0005, 16'h0003, R_GT, 4);
        run("s4 s zero",    1'b1, 16'h0000, 16'hFFFF, R_GT, 1);
        run("s4 s pos",     1'b1, 16'h7FFF, 16'h7FF0, R_GT, 4);

        // Stray start while busy is ignored
        launch(1'b0, 16'h1234, 16'h1235);
        @(negedge clk);
        start = 1'b1; a = 16'hFFFF; b = 16'h0000;
        @(negedge clk);
        start = 1'b0;
        n = 2;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        check("s5 ignored result", {29'd0, equal, greater, lower}, {29'd0, R_LT});
        check("s5 ignored latency", n, 4);
        // Start in the done cycle is accepted and clears the result
        start = 1'b1; smode = 1'b0; a = 16'h00F0; b = 16'h00E0;
        @(negedge clk);
        start = 1'b0;
        check("s5 b2b cleared", {27'd0, busy, done, equal, greater, lower}, 32'b10000);
        wait_done(n);
        check("s5 b2b result", {29'd0, equal, greater, lower}, {29'd0, R_GT});
        check("s5 b2b latency", n, 3);
        check("s5 b2b digits_used", {29'd0, digits_used}, 32'd3);

        // Asynchronous reset in the middle of a compare
        launch(1'b0, 16'h1234, 16'h1235);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("s6 rst outputs", {27'd0, busy, done, equal, greater, lower}, 32'd0);
        check("s6 rst digits_used", {29'd0, digits_used}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) stray_done++;
        end
        check("s6 no done", stray_done, 0);
        run("s6 after rst", 1'b0, 16'h0042, 16'h0024, R_GT, 3);

        // Exhaustive sweep on the WIDTH=4, DIGIT=1 instance
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    sxa = 4'(i);
                    sxb = 4'(j);
                    if (i == j)
                        exp_s = R_EQ;
                    else if (m == 1)
                        exp_s = (sxa > sxb) ? R_GT : R_LT;
                    else
                        exp_s = (i > j) ? R_GT : R_LT;
                    @(negedge clk);
                    s_start = 1'b1; s_smode = m[0]; s_a = 4'(i); s_b = 4'(j);
                    @(negedge clk);
                    s_start = 1'b0;
                    n = 0;
                    do begin
                        @(negedge clk);
                        n++;
                    end while (!s_done && n < 10);
                    check($sformatf("sweep m%0d a%0h b%0h", m, i, j),
                          {28'd0, s_done, s_equal, s_greater, s_lower}, {28'd0, 1'b1, exp_s});
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
